// File: rtl/fifo_pkg.sv
// Shared types and limits for the FIFO write arbiter.
package fifo_pkg;

  localparam int unsigned MAX_BURST_MIN = 1;
  localparam int unsigned MAX_BURST_MAX = 15;
  localparam int unsigned BEAT_W        = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Keeps an out-of-range burst length from making the beat compare unreachable.
  function automatic int unsigned clamp_burst(input int unsigned b);
    if (b < MAX_BURST_MIN) return MAX_BURST_MIN;
    if (b > MAX_BURST_MAX) return MAX_BURST_MAX;
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_vld,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_cidx;

  // Walk the requesters starting one past the last grantee; the first hit wins.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cidx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cidx = IW'((int'(i_last) + k) % N_REQ);
      if (!o_vld && i_req[w_cidx]) begin
        o_vld = 1'b1;
        o_idx = w_cidx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words into a FIFO. The burst ends early when the owner drops req;
// a full FIFO only stalls the burst.
//
// state | meaning
// IDLE  | no grant held; arbitrate among pending requests
// BURST | owner holds the FIFO write port until limit or req drop
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 4,
  parameter type dat_t     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  dat_t                     req_data [N_REQ],
  output logic [N_REQ-1:0]         ack,
  output dat_t                     fifo_wdata,
  output logic                     fifo_wput,
  input  logic                     fifo_wrdy,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(clamp_burst(int'(MAX_BURST)) - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [OW-1:0]     r_owner, w_owner_nxt;
  logic [OW-1:0]     r_last_owner, w_last_nxt;
  logic              w_pick_vld;
  logic [OW-1:0]     w_pick_idx;
  logic              w_put;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (OW)
  ) u_rr_pick (
    .i_req  (req),
    .i_last (r_last_owner),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  // A write happens only for the owner, only with FIFO room, and never while
  // reset is asserted so a mid-burst reset cannot sneak out a final word.
  assign w_put      = (r_state == ST_BURST) && req[r_owner] && fifo_wrdy && !rst;
  assign fifo_wput  = w_put;
  assign fifo_wdata = req_data[r_owner];
  assign busy       = (r_state == ST_BURST) && !rst;
  assign owner      = r_owner;

  // One-hot acknowledge mirrors the write strobe on the owner's lane.
  always_comb begin
    ack = '0;
    if (w_put) ack[r_owner] = 1'b1;
  end

  // Next-state: grant in IDLE, count beats and decide burst exit in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_owner_nxt = w_pick_idx;
          w_beat_nxt  = '0;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (w_put) begin
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == BEAT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_owner      <= '0;
      r_last_owner <= OW'(N_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_data [N];
  logic [3:0] ack;
  logic [7:0] fifo_wdata;
  logic       fifo_wput;
  logic       fifo_wrdy;
  logic       busy;
  logic [1:0] owner;

  int   n_vec = 0;
  int   n_mis = 0;
  int   cnt   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .MAX_BURST (4),
    .dat_t     (logic [7:0])
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_wdata (fifo_wdata),
    .fifo_wput  (fifo_wput),
    .fifo_wrdy  (fifo_wrdy),
    .busy       (busy),
    .owner      (owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fresh, requester-distinct data every cycle so stale or wrong-lane words show up.
  task automatic drive(input logic [3:0] r, input logic w);
    req       = r;
    fifo_wrdy = w;
    cnt++;
    for (int i = 0; i < N; i++) req_data[i] = 8'((i << 6) | (cnt & 63));
  endtask

  // One clock cycle: a = expected acked requester (-1 none), b = expected busy,
  // o = expected owner (-1 don't care).
  task automatic cyc(input string tag, input logic [3:0] r, input logic w,
                     input int a, input logic b, input int o);
    drive(r, w);
    #2;
    chk({tag, " busy"}, 32'(busy), 32'(b));
    if (a >= 0) begin
      sb.push_back('{own: 2'(a), dat: req_data[a]});
      chk({tag, " ack"}, 32'(ack), 32'(1 << a));
    end else begin
      chk({tag, " ack"}, 32'(ack), 32'd0);
    end
    if (o >= 0) chk({tag, " owner"}, 32'(owner), 32'(o));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    drive(r, 1'b1);
    #2;
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst wput", 32'(fifo_wput), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst owner", 32'(owner), 32'd0);
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst ack", 32'(ack), 32'd0);
    rst = 1'b0;
  endtask

  // Monitor: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (fifo_wput !== 1'b0) begin : mon
      exp_t e;
      chk("wput with wrdy low", 32'(fifo_wrdy), 32'd1);
      chk("sb has entry for put", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("put wdata", 32'(fifo_wdata), 32'(e.dat));
        chk("put owner", 32'(owner), 32'(e.own));
        chk("put ack", 32'(ack), 32'(1 << e.own));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[5];
    gseq = '{0, 1, 2, 3, 0};
    rst       = 1'b1;
    req       = '0;
    fifo_wrdy = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    @(posedge clk);
    #1;
    do_reset(4'b0000);

    // Single requester: 4 words, one arbitration cycle, 4 more.
    cyc("A arb", 4'b0001, 1'b1, -1, 1'b0, -1);
    for (int k = 0; k < 4; k++) cyc("A burst1", 4'b0001, 1'b1, 0, 1'b1, 0);
    cyc("A gap", 4'b0001, 1'b1, -1, 1'b0, 0);
    for (int k = 0; k < 4; k++) cyc("A burst2", 4'b0001, 1'b1, 0, 1'b1, 0);
    cyc("A idle", 4'b0000, 1'b1, -1, 1'b0, 0);

    // All requesting: round-robin 0,1,2,3,0 with 4 words each.
    do_reset(4'b0000);
    for (int g = 0; g < 5; g++) begin
      cyc("B arb", 4'b1111, 1'b1, -1, 1'b0, -1);
      for (int k = 0; k < 4; k++) cyc("B burst", 4'b1111, 1'b1, gseq[g], 1'b1, gseq[g]);
    end

    // Owner 2 stalled by a full FIFO after 1 beat; non-owners ignored.
    cyc("C arb", 4'b0100, 1'b1, -1, 1'b0, -1);
    cyc("C beat1", 4'b1111, 1'b1, 2, 1'b1, 2);
    for (int k = 0; k < 5; k++) cyc("C stall", 4'b1111, 1'b0, -1, 1'b1, 2);
    for (int k = 0; k < 3; k++) cyc("C resume", 4'b1111, 1'b1, 2, 1'b1, 2);
    cyc("C idle", 4'b0000, 1'b1, -1, 1'b0, 2);

    // Owner 1 drops req after 2 beats; requester 3 takes over.
    do_reset(4'b0000);
    cyc("D arb", 4'b0010, 1'b1, -1, 1'b0, -1);
    for (int k = 0; k < 2; k++) cyc("D beat", 4'b1010, 1'b1, 1, 1'b1, 1);
    cyc("D drop", 4'b1000, 1'b1, -1, 1'b1, 1);
    cyc("D rearb", 4'b1000, 1'b1, -1, 1'b0, 1);
    cyc("D own3", 4'b1000, 1'b1, 3, 1'b1, 3);

    // Reset mid-burst of owner 3, then requester 0 wins first.
    do_reset(4'b1001);
    cyc("E arb", 4'b1001, 1'b1, -1, 1'b0, 0);
    for (int k = 0; k < 2; k++) cyc("E own0", 4'b1001, 1'b1, 0, 1'b1, 0);
    cyc("E drop", 4'b0000, 1'b1, -1, 1'b1, 0);
    cyc("E idle", 4'b0000, 1'b1, -1, 1'b0, 0);

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
